// File: rtl/serial_tx_output_shifter_reg_pkg.sv
// Shared serial-port constants for the transmit shifter.
package serial_tx_output_shifter_reg_pkg;

  localparam int unsigned SERIAL_DATA_BITS  = 8;
  localparam logic        SERIAL_IDLE_LEVEL = 1'b1;

  // Frame lengths selected by SCON.SM0 (modes 0/1 vs 2/3).
  localparam logic [3:0]  SERIAL_FRAME_LEN_8 = 4'd8;
  localparam logic [3:0]  SERIAL_FRAME_LEN_9 = 4'd9;

  function automatic logic [3:0] serial_frame_len(input logic sm0);
    return sm0 ? SERIAL_FRAME_LEN_9 : SERIAL_FRAME_LEN_8;
  endfunction

endpackage

// File: rtl/serial_tx_output_shifter_reg.sv
// Transmit parallel-to-serial shifter: loads SBUF (+TB8), shifts LSB first
// on strobes, flags the last data bit and masks the line for stop bits.
module serial_tx_output_shifter_reg
  import serial_tx_output_shifter_reg_pkg::*;
(
  input  logic       serial_clock_i,
  input  logic       serial_reset_i_b,
  input  logic       serial_start_shifter_reg_i,
  input  logic       serial_shift_i,
  input  logic       serial_stop_bit_gen_i,
  input  logic       serial_scon3_tb8_i,
  input  logic       serial_scon7_sm0_i,
  input  logic [7:0] serial_data_sbuf_i,
  output logic       serial_data_tx_o,
  output logic       serial_end_bit_o
);

  logic [SERIAL_DATA_BITS:0] sr_q, sr_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [3:0]                len_q, len_d;
  logic                      busy_q, busy_d;
  logic                      tx_q, tx_d;
  logic                      end_q, end_d;
  logic [3:0]                cnt_inc;

  assign cnt_inc = cnt_q + 4'd1;

  // Next-state: load beats shift; shift only advances an active frame.
  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    len_d  = len_q;
    busy_d = busy_q;
    end_d  = end_q;
    if (serial_start_shifter_reg_i) begin
      // Top bit is TB8 in 9-bit modes, otherwise a mark so shifting stays idle-high.
      sr_d   = {(serial_scon7_sm0_i ? serial_scon3_tb8_i : SERIAL_IDLE_LEVEL),
                serial_data_sbuf_i};
      len_d  = serial_frame_len(serial_scon7_sm0_i);
      cnt_d  = 4'd0;
      busy_d = 1'b1;
      end_d  = 1'b0;
    end else if (serial_shift_i && busy_q) begin
      sr_d  = {SERIAL_IDLE_LEVEL, sr_q[SERIAL_DATA_BITS:1]};
      cnt_d = cnt_inc;
      if (cnt_inc == len_q) begin
        busy_d = 1'b0;
        end_d  = 1'b1;
      end
    end
    // Output follows next-state so each strobe shows on the line one edge later.
    tx_d = (serial_stop_bit_gen_i || !busy_d) ? SERIAL_IDLE_LEVEL : sr_d[0];
  end

  // State and output registers with synchronous reset to idle mark.
  always_ff @(posedge serial_clock_i) begin
    if (serial_reset_i_b) begin
      sr_q   <= '1;
      cnt_q  <= 4'd0;
      len_q  <= SERIAL_FRAME_LEN_8;
      busy_q <= 1'b0;
      tx_q   <= SERIAL_IDLE_LEVEL;
      end_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      busy_q <= busy_d;
      tx_q   <= tx_d;
      end_q  <= end_d;
    end
  end

  assign serial_data_tx_o = tx_q;
  assign serial_end_bit_o = end_q;

endmodule

// File: tb/tb_serial_tx_output_shifter_reg.sv
// Self-checking bench for the UART transmit shifter against a frame-index model.
module tb_serial_tx_output_shifter_reg;

  logic       clk = 1'b0;
  logic       rst, start, shift, stop, tb8, sm0;
  logic [7:0] sbuf;
  logic       tx, endb;

  int vecs = 0;
  int errs = 0;

  // Reference model: the frame as an array of bits and a bit index.
  logic m_bits [0:8];
  int   m_n    = 8;
  int   m_idx  = 0;
  bit   m_busy = 0;
  bit   m_end  = 0;
  bit   m_stop = 0;

  serial_tx_output_shifter_reg dut (
    .serial_clock_i             (clk),
    .serial_reset_i_b           (rst),
    .serial_start_shifter_reg_i (start),
    .serial_shift_i             (shift),
    .serial_stop_bit_gen_i      (stop),
    .serial_scon3_tb8_i         (tb8),
    .serial_scon7_sm0_i         (sm0),
    .serial_data_sbuf_i         (sbuf),
    .serial_data_tx_o           (tx),
    .serial_end_bit_o           (endb)
  );

  always #5 clk = ~clk;

  function automatic logic m_tx();
    if (m_stop || !m_busy) return 1'b1;
    return m_bits[m_idx];
  endfunction

  // Apply one cycle of inputs, advance the model, then sample after the edge.
  task automatic tick(input logic r, input logic st, input logic sh,
                      input logic sp, input logic t8, input logic s0,
                      input logic [7:0] d);
    rst = r; start = st; shift = sh; stop = sp; tb8 = t8; sm0 = s0; sbuf = d;
    @(posedge clk);
    m_stop = sp;
    if (r) begin
      m_busy = 0; m_end = 0; m_idx = 0; m_stop = 0;
    end else if (st) begin
      for (int i = 0; i < 8; i++) m_bits[i] = d[i];
      m_bits[8] = t8;
      m_n = s0 ? 9 : 8;
      m_idx = 0; m_busy = 1; m_end = 0;
    end else if (sh && m_busy) begin
      m_idx++;
      if (m_idx == m_n) begin m_busy = 0; m_end = 1; end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0, 0, 0, 8'h00);
    tick(1, 0, 0, 0, 0, 0, 8'h00);
    vecs++;
    if (tx !== 1'b1 || endb !== 1'b0) begin
      errs++; $display("FAIL reset: tx=%b end=%b, need tx=1 end=0", tx, endb);
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 0, 0, 0, 8'h00);
      vecs++;
      if (tx !== 1'b1 || endb !== 1'b0) begin
        errs++; $display("FAIL idle_shift %0d: tx=%b end=%b, need tx=1 end=0", i, tx, endb);
      end
    end
  endtask

  task automatic test_mode01();
    logic [8:0] exp_seq;
    exp_seq = 9'b1_1101_0101; // index k = tx after k strobes
    tick(0, 1, 0, 0, 0, 0, 8'hD5);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) tick(0, 0, 1, 0, 0, 0, 8'h3C);
      vecs++;
      if (tx !== exp_seq[k] || tx !== m_tx()) begin
        errs++; $display("FAIL mode01 bit %0d: tx=%b need %b", k, tx, exp_seq[k]);
      end
      vecs++;
      if (endb !== (k == 8)) begin
        errs++; $display("FAIL mode01 end after %0d strobes: got %b need %b", k, endb, (k == 8));
      end
      idle(1);
    end
    idle(4);
    vecs++;
    if (endb !== 1'b1 || tx !== 1'b1) begin
      errs++; $display("FAIL mode01 end_hold: end=%b tx=%b, need 1 1", endb, tx);
    end
  endtask

  task automatic test_mode23();
    tick(0, 1, 0, 0, 0, 1, 8'hFF);
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) tick(0, 0, 1, 0, 1, 0, 8'h00);
      vecs++;
      if (tx !== (k != 8) || tx !== m_tx()) begin
        errs++; $display("FAIL mode23 bit %0d: tx=%b need %b", k, tx, (k != 8));
      end
      vecs++;
      if (endb !== (k == 9)) begin
        errs++; $display("FAIL mode23 end after %0d strobes: got %b need %b", k, endb, (k == 9));
      end
    end
  endtask

  task automatic test_stop_mask();
    tick(0, 1, 0, 0, 0, 0, 8'h00);
    tick(0, 0, 1, 0, 0, 0, 8'h00);
    tick(0, 0, 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 1, 0, 0, 8'h00);
      vecs++;
      if (tx !== 1'b1) begin
        errs++; $display("FAIL stop_mask cycle %0d: tx=%b need 1", i, tx);
      end
    end
    idle(1);
    vecs++;
    if (tx !== 1'b0) begin
      errs++; $display("FAIL stop_release: tx=%b need 0", tx);
    end
    // Count must be unaffected: six more strobes end an 8-bit frame.
    for (int k = 3; k <= 8; k++) begin
      tick(0, 0, 1, 0, 0, 0, 8'h00);
      vecs++;
      if (endb !== (k == 8) || tx !== (k == 8)) begin
        errs++; $display("FAIL stop_count strobe %0d: end=%b tx=%b need %b", k, endb, tx, (k == 8));
      end
    end
  endtask

  task automatic test_abort();
    tick(0, 1, 0, 0, 0, 0, 8'hFF);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 0, 0, 0, 8'h00);
    tick(0, 1, 0, 0, 0, 0, 8'h00);
    vecs++;
    if (tx !== 1'b0 || endb !== 1'b0) begin
      errs++; $display("FAIL abort_reload: tx=%b end=%b, need 0 0", tx, endb);
    end
    for (int k = 1; k <= 8; k++) begin
      tick(0, 0, 1, 0, 0, 0, 8'h00);
      vecs++;
      if (endb !== (k == 8)) begin
        errs++; $display("FAIL abort_restart strobe %0d: end=%b need %b", k, endb, (k == 8));
      end
    end
    tick(0, 1, 1, 0, 0, 0, 8'h01);
    vecs++;
    if (tx !== 1'b1 || endb !== 1'b0) begin
      errs++; $display("FAIL start_and_shift: tx=%b end=%b, need 1 0", tx, endb);
    end
    tick(0, 0, 1, 0, 0, 0, 8'h00);
    vecs++;
    if (tx !== 1'b0) begin
      errs++; $display("FAIL start_and_shift next: tx=%b need 0", tx);
    end
  endtask

  task automatic test_midreset();
    tick(0, 1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 0, 0, 0, 8'h00);
    tick(1, 0, 0, 0, 0, 0, 8'h00);
    vecs++;
    if (tx !== 1'b1 || endb !== 1'b0) begin
      errs++; $display("FAIL midreset: tx=%b end=%b, need 1 0", tx, endb);
    end
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 1, 0, 0, 0, 8'h00);
      vecs++;
      if (tx !== 1'b1 || endb !== 1'b0) begin
        errs++; $display("FAIL midreset_shift %0d: tx=%b end=%b, need 1 0", i, tx, endb);
      end
    end
  endtask

  task automatic test_random();
    logic r, st, sh, sp;
    for (int i = 0; i < 2000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      st = ($urandom_range(0, 14) == 0);
      sh = ($urandom_range(0, 2) == 0);
      sp = ($urandom_range(0, 5) == 0);
      tick(r, st, sh, sp, 1'($urandom), 1'($urandom), 8'($urandom));
      vecs++;
      if (tx !== m_tx() || endb !== m_end) begin
        errs++; $display("FAIL random cycle %0d: tx=%b end=%b need tx=%b end=%b",
                         i, tx, endb, m_tx(), m_end);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode01();
    test_mode23();
    test_stop_mask();
    test_abort();
    test_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
